uart_rx_demux: RTL

- Receive-side counterpart of the UART transmit multiplexer.
- Drains bytes from the UART RX FIFO, classifies each by its 3-bit module code in bits [7:5], and routes it to one of four per-module holding registers, each with a one-cycle valid strobe.
- Provides a link watchdog so game logic can detect loss of the remote board.
- Sits between the UART core (rx FIFO side) and game_state_sel / gloves/shoot / score / mouse consumer logic.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_link_watchdog.sv | 41 ++++
 rtl/uart_rx_demux.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: module codes, byte classes and receive FSM states shared by the UART tx/rx paths
//   code_t     : 3-bit module code carried in byte[7:5]
//   cls_t      : consumer class a code is routed to
//   rx_state_t : receive demux FSM states
//   code_class : total mapping from code to class
package uart_pkg;

   typedef enum logic [2:0] {
      CODE_GAME    = 3'b000,
      CODE_MOUSE_A = 3'b001,
      CODE_MOUSE_B = 3'b010,
      CODE_SHOOT_0 = 3'b011,
      CODE_SHOOT_1 = 3'b100,
      CODE_SHOOT_2 = 3'b101,
      CODE_SHOOT_3 = 3'b110,
      CODE_SCORE   = 3'b111
   } code_t;

   typedef enum logic [1:0] {CLS_GAME, CLS_MOUSE, CLS_SHOOT, CLS_SCORE} cls_t;

   typedef enum logic [1:0] {IDLE, POP, DISPATCH, GAP} rx_state_t;

   function automatic cls_t code_class(input code_t c);
      return c == CODE_GAME                         ? CLS_GAME  :
             (c == CODE_MOUSE_A || c == CODE_MOUSE_B) ? CLS_MOUSE :
             c == CODE_SCORE                        ? CLS_SCORE : CLS_SHOOT;
   endfunction

endpackage

// File: rtl/uart_link_watchdog.sv
// uart_link_watchdog: flags the remote link alive while bytes keep arriving
//   clk, rst   : clock, synchronous active-high reset
//   byte_seen  : high for one cycle per received byte
//   link_alive : registered, high until TIMEOUT_CYCLES cycles pass without a byte
module uart_link_watchdog #(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int CNT_W          = 21
) (
   input  logic clk,
   input  logic rst,
   input  logic byte_seen,
   output logic link_alive
);
   import uart_pkg::*;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alive_q, alive_d;

   // The count reads 0 in the first idle cycle after a byte, so it reads
   // LIMIT-1 in the TIMEOUT_CYCLES-th idle cycle; alive is registered from
   // the next count so that it is already low in that cycle. A byte always wins.
   always_comb begin
      cnt_d   = byte_seen ? '0 : (cnt_q == LIMIT ? cnt_q : cnt_q + 1'b1);
      alive_d = byte_seen | (alive_q & (cnt_d < LIMIT - 1'b1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         alive_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         alive_q <= alive_d;
      end
   end

   assign link_alive = alive_q;

endmodule

// File: rtl/uart_rx_demux.sv
// uart_rx_demux: drains the UART RX FIFO and routes each byte to a per-module holding register
//   clk, rst                 : clock, synchronous active-high reset
//   rx_empty, r_data         : RX FIFO empty flag and first-word-fall-through head byte
//   rd_uart                  : one-cycle pop request
//   data_*                   : last byte of each class (game/mouse/shoot/score)
//   *_valid                  : one-cycle strobe when the matching register updates
//   link_alive               : high while bytes arrive within TIMEOUT_CYCLES
module uart_rx_demux #(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int CNT_W          = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   output logic [7:0] data_game_state_sel,
   output logic [7:0] data_mouse_control,
   output logic [7:0] data_shoot_control,
   output logic [7:0] data_score_control,
   output logic       game_state_valid,
   output logic       mouse_valid,
   output logic       shoot_valid,
   output logic       score_valid,
   output logic       link_alive
);
   import uart_pkg::*;

   rx_state_t  state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       rd_q, rd_d;
   logic [7:0] game_q, game_d, mouse_q, mouse_d, shoot_q, shoot_d, score_q, score_d;
   logic       game_v_q, game_v_d, mouse_v_q, mouse_v_d;
   logic       shoot_v_q, shoot_v_d, score_v_q, score_v_d;
   logic       disp;
   cls_t       cls;

   // Outputs are registered from the next state so the pop strobe lines up
   // with the POP state and the valid strobes with the DISPATCH state.
   always_comb begin
      state_d   = state_q == IDLE     ? (rx_empty ? IDLE : POP) :
                  state_q == POP      ? DISPATCH :
                  state_q == DISPATCH ? GAP : IDLE;
      byte_d    = (state_q == IDLE && !rx_empty) ? r_data : byte_q;
      rd_d      = state_d == POP;
      disp      = state_d == DISPATCH;
      cls       = code_class(code_t'(byte_q[7:5]));
      game_v_d  = disp && cls == CLS_GAME;
      mouse_v_d = disp && cls == CLS_MOUSE;
      shoot_v_d = disp && cls == CLS_SHOOT;
      score_v_d = disp && cls == CLS_SCORE;
      game_d    = game_v_d  ? byte_q : game_q;
      mouse_d   = mouse_v_d ? byte_q : mouse_q;
      shoot_d   = shoot_v_d ? byte_q : shoot_q;
      score_d   = score_v_d ? byte_q : score_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         byte_q    <= '0;
         rd_q      <= 1'b0;
         game_q    <= '0;
         mouse_q   <= '0;
         shoot_q   <= '0;
         score_q   <= '0;
         game_v_q  <= 1'b0;
         mouse_v_q <= 1'b0;
         shoot_v_q <= 1'b0;
         score_v_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         rd_q      <= rd_d;
         game_q    <= game_d;
         mouse_q   <= mouse_d;
         shoot_q   <= shoot_d;
         score_q   <= score_d;
         game_v_q  <= game_v_d;
         mouse_v_q <= mouse_v_d;
         shoot_v_q <= shoot_v_d;
         score_v_q <= score_v_d;
      end
   end

   uart_link_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_wd (
      .clk       (clk),
      .rst       (rst),
      .byte_seen (state_q == DISPATCH),
      .link_alive(link_alive)
   );

   assign rd_uart             = rd_q;
   assign data_game_state_sel = game_q;
   assign data_mouse_control  = mouse_q;
   assign data_shoot_control  = shoot_q;
   assign data_score_control  = score_q;
   assign game_state_valid    = game_v_q;
   assign mouse_valid         = mouse_v_q;
   assign shoot_valid         = shoot_v_q;
   assign score_valid         = score_v_q;

endmodule
